// File: rtl/shf_sched_if.sv
// Request, shifter-drive and writeback bundle for the shared-shifter scheduler.
interface shf_sched_if #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAGW  = 9
);
    localparam int unsigned OPW = 4 + 4 + 1 + 1 + 1 + 6 + WIDTH + WIDTH + TAGW;

    logic [1:0]       req_vld;
    logic [1:0]       req_rdy;
    logic [OPW-1:0]   req0_op;
    logic [OPW-1:0]   req1_op;

    logic [3:0]       shf_bit_en;
    logic [3:0]       shf_sz;
    logic             shf_dir;
    logic             shf_arith;
    logic [WIDTH-1:0] shf_val0;
    logic [5:0]       shf_val1;
    logic [WIDTH-1:0] shf_res;
    logic             shf_coutR;
    logic [3:0]       shf_coutL;

    logic             res_vld;
    logic             res_port;
    logic [TAGW-1:0]  res_tag;
    logic [WIDTH-1:0] res_val;
    logic             res_cf;

    // Scheduler side.
    modport slave (
        input  req_vld, req0_op, req1_op, shf_res, shf_coutR, shf_coutL,
        output req_rdy, shf_bit_en, shf_sz, shf_dir, shf_arith, shf_val0, shf_val1,
        output res_vld, res_port, res_tag, res_val, res_cf
    );

    // Issue ports, shifter and writeback side.
    modport master (
        output req_vld, req0_op, req1_op, shf_res, shf_coutR, shf_coutL,
        input  req_rdy, shf_bit_en, shf_sz, shf_dir, shf_arith, shf_val0, shf_val1,
        input  res_vld, res_port, res_tag, res_val, res_cf
    );
endinterface

// File: rtl/shf_sched.sv
// Round-robin scheduler sharing one 64-bit shifter between two ALU issue ports;
// double-precision shifts run as two ORed passes.
module shf_sched #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned TAGW  = 9
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    shf_sched_if.slave bus
);
    localparam int unsigned CNTW = 6;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] P1   = 2'd1;
    localparam logic [1:0] P2   = 2'd2;

    localparam logic [3:0] SZ_DBL = 4'b1000;

    typedef struct packed {
        logic [3:0]       bit_en;
        logic [3:0]       sz;
        logic             dir;
        logic             arith;
        logic             dbl;
        logic [CNTW-1:0]  cnt;
        logic [WIDTH-1:0] val_lo;
        logic [WIDTH-1:0] val_hi;
        logic [TAGW-1:0]  tag;
    } op_t;

    logic [1:0]       state_q, state_d;
    op_t              op_q, op_d, sel_op;
    logic             port_q, port_d;
    logic             rr_q, rr_d;
    logic             grant_port, accept_ok, hs, two_pass, finish, cf_now;
    logic [1:0]       rdy;
    logic [WIDTH-1:0] acc_q;
    logic             cf_q;
    logic             res_vld_q, res_port_q, res_cf_q;
    logic [TAGW-1:0]  res_tag_q;
    logic [WIDTH-1:0] res_val_q;
    logic             unused_coutl;

    assign unused_coutl = ^bus.shf_coutL[1:0];

    // Arbitration, acceptance and next-state / op-register selection.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        port_d     = port_q;
        rr_d       = rr_q;
        grant_port = (bus.req_vld == 2'b11) ? rr_q : bus.req_vld[1];
        sel_op     = grant_port ? op_t'(bus.req1_op) : op_t'(bus.req0_op);
        accept_ok  = rst & ~flush &
                     ((state_q == IDLE) | ((state_q == P1) & ~op_q.dbl) | (state_q == P2));
        rdy        = accept_ok ? (grant_port ? 2'b10 : 2'b01) : 2'b00;
        hs         = |(bus.req_vld & rdy);
        two_pass   = (state_q == P1) & op_q.dbl & (op_q.cnt != '0);
        finish     = ((state_q == P1) & ~two_pass) | (state_q == P2);
        if (flush) begin
            state_d = IDLE;
            op_d    = '0;
        end else if (hs) begin
            state_d = P1;
            op_d    = sel_op;
            port_d  = grant_port;
            rr_d    = ~grant_port;
        end else if (two_pass) begin
            state_d = P2;
        end else if (finish) begin
            state_d = IDLE;
            op_d    = '0;
        end
    end

    assign bus.req_rdy = rdy;

    // Shifter drive from the op register; second pass shifts val_hi the other way by 64-cnt.
    always_comb begin
        bus.shf_bit_en = '0;
        bus.shf_sz     = '0;
        bus.shf_dir    = 1'b0;
        bus.shf_arith  = 1'b0;
        bus.shf_val0   = '0;
        bus.shf_val1   = '0;
        case (state_q)
            P1: begin
                bus.shf_bit_en = op_q.bit_en;
                bus.shf_sz     = op_q.dbl ? SZ_DBL : op_q.sz;
                bus.shf_dir    = op_q.dir;
                bus.shf_arith  = op_q.arith & ~op_q.dbl;
                bus.shf_val0   = op_q.val_lo;
                bus.shf_val1   = op_q.cnt;
            end
            P2: begin
                bus.shf_bit_en = op_q.bit_en;
                bus.shf_sz     = SZ_DBL;
                bus.shf_dir    = ~op_q.dir;
                bus.shf_val0   = op_q.val_hi;
                bus.shf_val1   = CNTW'(0) - op_q.cnt;
            end
            default: ;
        endcase
        cf_now = bus.shf_dir ? bus.shf_coutR
                             : (bus.shf_sz[3] ? bus.shf_coutL[3] : bus.shf_coutL[2]);
    end

    // State, op register and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            port_q  <= 1'b0;
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            port_q  <= port_d;
            rr_q    <= rr_d;
        end
    end

    // First-pass accumulator and carry for double shifts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= '0;
            cf_q  <= 1'b0;
        end else if (two_pass & ~flush) begin
            acc_q <= bus.shf_res;
            cf_q  <= cf_now;
        end
    end

    // Writeback register; a flush drops the result finishing at the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            res_vld_q  <= 1'b0;
            res_port_q <= 1'b0;
            res_tag_q  <= '0;
            res_val_q  <= '0;
            res_cf_q   <= 1'b0;
        end else begin
            res_vld_q <= finish & ~flush;
            if (finish & ~flush) begin
                res_port_q <= port_q;
                res_tag_q  <= op_q.tag;
                res_val_q  <= (state_q == P2) ? (acc_q | bus.shf_res) : bus.shf_res;
                res_cf_q   <= (state_q == P2) ? cf_q : (cf_now & ~op_q.dbl);
            end
        end
    end

    assign bus.res_vld  = res_vld_q;
    assign bus.res_port = res_port_q;
    assign bus.res_tag  = res_tag_q;
    assign bus.res_val  = res_val_q;
    assign bus.res_cf   = res_cf_q;
endmodule

// File: tb/tb_shf_sched.sv
// Self-checking bench for shf_sched with a behavioural shifter stub and result model.
module tb_shf_sched;
    typedef struct packed {
        logic [3:0]  bit_en;
        logic [3:0]  sz;
        logic        dir;
        logic        arith;
        logic        dbl;
        logic [5:0]  cnt;
        logic [63:0] val_lo;
        logic [63:0] val_hi;
        logic [8:0]  tag;
    } op_t;

    typedef struct {
        int          due;
        logic        port;
        logic [8:0]  tag;
        logic [63:0] val;
        logic        cf;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic flush = 1'b0;
    int   vectors = 0;
    int   errors = 0;
    int   sh_n;

    shf_sched_if #(.WIDTH(64), .TAGW(9)) bus ();

    shf_sched #(.WIDTH(64), .TAGW(9)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Shifter stub: plain shift plus deterministic carry outputs.
    always_comb begin
        sh_n = int'(bus.shf_val1);
        if (bus.shf_dir)
            bus.shf_res = bus.shf_arith ? 64'($signed(bus.shf_val0) >>> sh_n) : (bus.shf_val0 >> sh_n);
        else
            bus.shf_res = bus.shf_val0 << sh_n;
        bus.shf_coutR = (sh_n == 0) ? bus.shf_val0[0] : bus.shf_val0[sh_n-1];
        bus.shf_coutL = {bus.shf_val0[63] ^ bus.shf_val1[0], bus.shf_val0[31], 2'b11};
    end

    function automatic op_t mk_op(logic [3:0] be, logic [3:0] sz, logic dir, logic ar, logic dbl,
                                  logic [5:0] cnt, logic [63:0] lo, logic [63:0] hi, logic [8:0] tag);
        op_t o;
        o.bit_en = be; o.sz = sz; o.dir = dir; o.arith = ar; o.dbl = dbl;
        o.cnt = cnt; o.val_lo = lo; o.val_hi = hi; o.tag = tag;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.bit_en = 4'($urandom); o.sz = 4'($urandom); o.dir = 1'($urandom);
        o.arith = 1'($urandom); o.dbl = 1'($urandom);
        o.cnt = ($urandom_range(0, 5) == 0) ? 6'd0 : 6'($urandom);
        o.val_lo = {$urandom, $urandom}; o.val_hi = {$urandom, $urandom}; o.tag = 9'($urandom);
        return o;
    endfunction

    // Expected architectural result of an op.
    function automatic logic [63:0] ref_val(op_t o);
        int c = int'(o.cnt);
        if (o.dbl && c != 0)
            return o.dir ? ((o.val_lo >> c) | (o.val_hi << (64 - c)))
                         : ((o.val_lo << c) | (o.val_hi >> (64 - c)));
        if (o.dir)
            return (o.arith && !o.dbl) ? 64'($signed(o.val_lo) >>> c) : (o.val_lo >> c);
        return o.val_lo << c;
    endfunction

    // Expected carry: taken from the first pass as the stub reports it.
    function automatic logic ref_cf(op_t o);
        int c = int'(o.cnt);
        logic sz3;
        if (o.dbl && c == 0) return 1'b0;
        if (o.dir) return (c == 0) ? o.val_lo[0] : o.val_lo[c-1];
        sz3 = o.dbl ? 1'b1 : o.sz[3];
        return sz3 ? (o.val_lo[63] ^ o.cnt[0]) : o.val_lo[31];
    endfunction

    task automatic apply_reset();
        rst = 1'b0; flush = 1'b0; bus.req_vld = 2'b00;
        bus.req0_op = '0; bus.req1_op = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0; flush = 1'b0; bus.req_vld = 2'b11;
        bus.req0_op = rand_op(); bus.req1_op = rand_op();
        #3;
        vectors++;
        if ({bus.res_vld, bus.res_port, bus.res_tag, bus.res_val, bus.res_cf} !== '0) begin
            errors++; $display("FAIL reset_res: got vld=%b val=%h tag=%h want all 0", bus.res_vld, bus.res_val, bus.res_tag);
        end
        vectors++;
        if ({bus.shf_bit_en, bus.shf_sz, bus.shf_dir, bus.shf_arith, bus.shf_val0, bus.shf_val1} !== '0) begin
            errors++; $display("FAIL reset_shf: got val0=%h val1=%0d sz=%b want all 0", bus.shf_val0, bus.shf_val1, bus.shf_sz);
        end
        vectors++;
        if (bus.req_rdy !== 2'b00) begin
            errors++; $display("FAIL reset_rdy: got %b want 00", bus.req_rdy);
        end
        apply_reset();
    endtask

    task automatic test_single();
        apply_reset();
        @(negedge clk);
        bus.req0_op = mk_op(4'b0110, 4'b1000, 1'b1, 1'b0, 1'b0, 6'd4, 64'hF0, 64'h0, 9'd5);
        bus.req_vld = 2'b01;
        #1;
        vectors++;
        if (bus.req_rdy !== 2'b01) begin errors++; $display("FAIL single_rdy: got %b want 01", bus.req_rdy); end
        @(negedge clk);
        bus.req_vld = 2'b00;
        vectors++;
        if (bus.res_vld !== 1'b0 || bus.shf_val1 !== 6'd4 || bus.shf_dir !== 1'b1 || bus.shf_val0 !== 64'hF0) begin
            errors++; $display("FAIL single_p1: got vld=%b val1=%0d dir=%b val0=%h want 0/4/1/f0",
                               bus.res_vld, bus.shf_val1, bus.shf_dir, bus.shf_val0);
        end
        @(negedge clk);
        vectors++;
        if (bus.res_vld !== 1'b1 || bus.res_val !== 64'hF || bus.res_cf !== 1'b0 ||
            bus.res_tag !== 9'd5 || bus.res_port !== 1'b0) begin
            errors++; $display("FAIL single_res: got vld=%b val=%h cf=%b tag=%0d port=%b want 1/f/0/5/0",
                               bus.res_vld, bus.res_val, bus.res_cf, bus.res_tag, bus.res_port);
        end
        @(negedge clk);
        vectors++;
        if (bus.res_vld !== 1'b0) begin errors++; $display("FAIL single_pulse: got vld=%b want 0", bus.res_vld); end
    endtask

    task automatic test_round_robin();
        op_t o0, o1;
        logic [1:0] exp_rdy;
        logic [8:0] exp_tag;
        apply_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                exp_tag = ((i - 2) % 2 == 0) ? 9'(16 + i - 2) : 9'(32 + i - 2);
                vectors++;
                if (bus.res_vld !== 1'b1 || bus.res_port !== 1'((i - 2) % 2) || bus.res_tag !== exp_tag) begin
                    errors++; $display("FAIL rr_res[%0d]: got vld=%b port=%b tag=%0d want 1/%0d/%0d",
                                       i, bus.res_vld, bus.res_port, bus.res_tag, (i - 2) % 2, exp_tag);
                end
            end
            o0 = rand_op(); o0.dbl = 1'b0; o0.tag = 9'(16 + i);
            o1 = rand_op(); o1.dbl = 1'b0; o1.tag = 9'(32 + i);
            bus.req0_op = o0; bus.req1_op = o1; bus.req_vld = 2'b11;
            #1;
            exp_rdy = (i % 2 == 0) ? 2'b01 : 2'b10;
            vectors++;
            if (bus.req_rdy !== exp_rdy) begin
                errors++; $display("FAIL rr_grant[%0d]: got %b want %b", i, bus.req_rdy, exp_rdy);
            end
        end
        @(negedge clk);
        bus.req_vld = 2'b00;
    endtask

    task automatic test_double();
        apply_reset();
        @(negedge clk);
        bus.req0_op = mk_op(4'b1111, 4'b0100, 1'b1, 1'b0, 1'b1, 6'd8, 64'h1122334455667788, 64'hAA, 9'd77);
        bus.req_vld = 2'b01;
        #1;
        vectors++;
        if (bus.req_rdy !== 2'b01) begin errors++; $display("FAIL dbl_rdy0: got %b want 01", bus.req_rdy); end
        @(negedge clk);
        #1;
        vectors++;
        if (bus.req_rdy !== 2'b00 || bus.shf_sz !== 4'b1000) begin
            errors++; $display("FAIL dbl_p1: got rdy=%b sz=%b want 00/1000", bus.req_rdy, bus.shf_sz);
        end
        @(negedge clk);
        bus.req_vld = 2'b00;
        vectors++;
        if (bus.shf_val1 !== 6'd56 || bus.shf_dir !== 1'b0 || bus.shf_val0 !== 64'hAA || bus.res_vld !== 1'b0) begin
            errors++; $display("FAIL dbl_p2: got val1=%0d dir=%b val0=%h vld=%b want 56/0/aa/0",
                               bus.shf_val1, bus.shf_dir, bus.shf_val0, bus.res_vld);
        end
        @(negedge clk);
        vectors++;
        if (bus.res_vld !== 1'b1 || bus.res_val !== 64'hAA11223344556677 || bus.res_cf !== 1'b1 || bus.res_tag !== 9'd77) begin
            errors++; $display("FAIL dbl_res: got vld=%b val=%h cf=%b tag=%0d want 1/aa11223344556677/1/77",
                               bus.res_vld, bus.res_val, bus.res_cf, bus.res_tag);
        end
    endtask

    task automatic test_dbl_zero();
        apply_reset();
        @(negedge clk);
        bus.req1_op = mk_op(4'b0011, 4'b0001, 1'b1, 1'b1, 1'b1, 6'd0, 64'h8123456789ABCDEF, 64'hFFFF, 9'd300);
        bus.req_vld = 2'b10;
        @(negedge clk);
        #1;
        vectors++;
        if (bus.shf_val1 !== 6'd0 || bus.shf_arith !== 1'b0 || bus.shf_sz !== 4'b1000 || bus.req_rdy !== 2'b00) begin
            errors++; $display("FAIL dbl0_p1: got val1=%0d arith=%b sz=%b rdy=%b want 0/0/1000/00",
                               bus.shf_val1, bus.shf_arith, bus.shf_sz, bus.req_rdy);
        end
        @(negedge clk);
        bus.req_vld = 2'b00;
        vectors++;
        if (bus.res_vld !== 1'b1 || bus.res_val !== 64'h8123456789ABCDEF || bus.res_cf !== 1'b0 || bus.res_port !== 1'b1) begin
            errors++; $display("FAIL dbl0_res: got vld=%b val=%h cf=%b port=%b want 1/8123456789abcdef/0/1",
                               bus.res_vld, bus.res_val, bus.res_cf, bus.res_port);
        end
        @(negedge clk);
        vectors++;
        if (bus.res_vld !== 1'b0) begin errors++; $display("FAIL dbl0_once: got vld=%b want 0", bus.res_vld); end
    endtask

    task automatic test_flush();
        apply_reset();
        @(negedge clk);
        bus.req0_op = mk_op(4'b1111, 4'b1000, 1'b0, 1'b0, 1'b1, 6'd12, {$urandom, $urandom}, {$urandom, $urandom}, 9'd9);
        bus.req_vld = 2'b01;
        @(negedge clk);
        bus.req_vld = 2'b00;
        @(negedge clk);
        bus.req1_op = mk_op(4'b0001, 4'b1000, 1'b1, 1'b0, 1'b0, 6'd1, 64'h6, 64'h0, 9'h33);
        bus.req_vld = 2'b10; flush = 1'b1;
        #1;
        vectors++;
        if (bus.req_rdy !== 2'b00) begin errors++; $display("FAIL flush_rdy: got %b want 00", bus.req_rdy); end
        @(negedge clk);
        flush = 1'b0;
        #1;
        vectors++;
        if (bus.req_rdy !== 2'b10 || bus.res_vld !== 1'b0) begin
            errors++; $display("FAIL flush_after: got rdy=%b vld=%b want 10/0", bus.req_rdy, bus.res_vld);
        end
        @(negedge clk);
        bus.req_vld = 2'b00;
        vectors++;
        if (bus.res_vld !== 1'b0) begin errors++; $display("FAIL flush_drop: got vld=%b want 0", bus.res_vld); end
        @(negedge clk);
        vectors++;
        if (bus.res_vld !== 1'b1 || bus.res_port !== 1'b1 || bus.res_tag !== 9'h33 || bus.res_val !== 64'h3) begin
            errors++; $display("FAIL flush_next: got vld=%b port=%b tag=%h val=%h want 1/1/33/3",
                               bus.res_vld, bus.res_port, bus.res_tag, bus.res_val);
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        @(negedge clk);
        bus.req0_op = mk_op(4'b1111, 4'b1000, 1'b1, 1'b0, 1'b0, 6'd3, 64'hFFFF0000, 64'h0, 9'd1);
        bus.req_vld = 2'b01;
        @(negedge clk);
        bus.req_vld = 2'b00;
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if ({bus.res_vld, bus.res_val, bus.res_cf, bus.shf_val0, bus.shf_val1, bus.shf_sz, bus.shf_dir, bus.shf_bit_en, bus.req_rdy} !== '0) begin
            errors++; $display("FAIL rstmid_out: got vld=%b val0=%h val1=%0d dir=%b rdy=%b want all 0",
                               bus.res_vld, bus.shf_val0, bus.shf_val1, bus.shf_dir, bus.req_rdy);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.req1_op = rand_op();
        bus.req_vld = 2'b11;
        #1;
        vectors++;
        if (bus.req_rdy !== 2'b01 || bus.res_vld !== 1'b0) begin
            errors++; $display("FAIL rstmid_rr: got rdy=%b vld=%b want 01/0", bus.req_rdy, bus.res_vld);
        end
        @(negedge clk);
        bus.req_vld = 2'b00;
        vectors++;
        if (bus.res_vld !== 1'b0) begin errors++; $display("FAIL rstmid_lost: got vld=%b want 0", bus.res_vld); end
    endtask

    task automatic test_random();
        exp_t       rq[$];
        exp_t       e;
        op_t        o0, o1, og;
        logic [1:0] v, exp_rdy;
        logic       gp, m_rr, m_block, exp_v;
        int         m_left, cyc;
        apply_reset();
        m_rr = 1'b0; m_block = 1'b0; m_left = 0; cyc = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            exp_v = (rq.size() > 0) && (rq[0].due == cyc);
            vectors++;
            if (bus.res_vld !== exp_v) begin
                errors++; $display("FAIL rand_vld[%0d]: got %b want %b", cyc, bus.res_vld, exp_v);
            end
            if (exp_v) begin
                e = rq.pop_front();
                vectors++;
                if (bus.res_val !== e.val || bus.res_tag !== e.tag || bus.res_port !== e.port || bus.res_cf !== e.cf) begin
                    errors++; $display("FAIL rand_res[%0d]: got val=%h tag=%h port=%b cf=%b want %h/%h/%b/%b",
                                       cyc, bus.res_val, bus.res_tag, bus.res_port, bus.res_cf, e.val, e.tag, e.port, e.cf);
                end
            end
            o0 = rand_op(); o1 = rand_op();
            v = (i < 490) ? 2'($urandom) : 2'b00;
            flush = (i < 490) && ($urandom_range(0, 15) == 0);
            bus.req0_op = o0; bus.req1_op = o1; bus.req_vld = v;
            #1;
            gp = (v == 2'b11) ? m_rr : v[1];
            exp_rdy = (!flush && !(m_left > 0 && m_block)) ? (gp ? 2'b10 : 2'b01) : 2'b00;
            vectors++;
            if (bus.req_rdy !== exp_rdy) begin
                errors++; $display("FAIL rand_rdy[%0d]: got %b want %b", cyc, bus.req_rdy, exp_rdy);
            end
            if (flush) begin
                m_left = 0; m_block = 1'b0;
                while (rq.size() > 0 && rq[$].due > cyc) void'(rq.pop_back());
            end else if ((v & exp_rdy) != 2'b00) begin
                og = gp ? o1 : o0;
                e.due  = cyc + ((og.dbl && og.cnt != 6'd0) ? 3 : 2);
                e.port = gp; e.tag = og.tag; e.val = ref_val(og); e.cf = ref_cf(og);
                rq.push_back(e);
                m_left = (og.dbl && og.cnt != 6'd0) ? 2 : 1;
                m_block = og.dbl;
                m_rr = ~gp;
            end else if (m_left > 0) begin
                m_left--; m_block = 1'b0;
            end
            cyc++;
        end
        flush = 1'b0;
        vectors++;
        if (rq.size() != 0) begin
            errors++; $display("FAIL rand_drain: got %0d results outstanding want 0", rq.size());
        end
    endtask

    initial begin
        bus.req_vld = 2'b00; bus.req0_op = '0; bus.req1_op = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_double();
        test_dbl_zero();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end
endmodule
